// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer around one shared full-adder cell.
// Operands are latched on an accepted start. One bit per clock, LSB first, is
// driven to the external full adder. Its sum/carry are captured back each clock
// and the WIDTH-bit result is reported with a one-cycle done pulse.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             carry_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    // Sum shift register with the new bit entering at the MSB; the extra bit
    // keeps the slice legal when WIDTH is 1.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] sum_shift;

    assign sum_ext   = {fa_s, sum_sh_q};
    assign sum_shift = sum_ext[WIDTH:1];

    // Full-adder drive is only live while running; idle/done present zeros.
    assign fa_a   = (state_q == StRun) & a_sh_q[0];
    assign fa_b   = (state_q == StRun) & b_sh_q[0];
    assign fa_cin = (state_q == StRun) & carry_q;

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

    // Sequencer FSM with datapath shift registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // Done accepts a new request directly so back-to-back adds have no gap.
                StIdle, StDone: begin
                    if (start) begin
                        a_sh_q   <= a;
                        b_sh_q   <= b;
                        carry_q  <= cin;
                        sum_sh_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end else begin
                        state_q  <= StIdle;
                    end
                end
                StRun: begin
                    sum_sh_q <= sum_shift;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    carry_q  <= fa_cout;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        // carry_q still holds the carry into the MSB on this edge.
                        sum_q   <= sum_shift;
                        cout_q  <= fa_cout;
                        ovf_q   <= fa_cout ^ carry_q;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
